// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the ROM round-robin arbiter slice.
package rom_arb_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DEPTH   = 8;
    localparam int DEF_NUM_REQ = 4;

    // Address width for a memory of 'depth' words (at least one bit).
    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Modulo-n increment used to advance the round-robin pointer.
    function automatic int next_ptr(input int ptr, input int n);
        return (ptr >= n - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i wins.
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic [$clog2(NUM_REQ)-1:0] idx_o
);

    localparam int IW = $clog2(NUM_REQ);

    logic found;
    int   cand;

    // Scan requests from the priority pointer, wrapping, and grant the first one.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = (int'(ptr_i) + off) % NUM_REQ;
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Shares one synchronous-read ROM among NUM_REQ requesters with round-robin
// grants; the read word is routed back to the winner one cycle later.
module rom_rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*addr_w(DEPTH)-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [WIDTH-1:0]              rsp_data,
    output logic                          rom_en,
    output logic [addr_w(DEPTH)-1:0]      rom_addr,
    input  logic [WIDTH-1:0]              rom_data
);

    localparam int AW = addr_w(DEPTH);
    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      prio_ptr_q, prio_ptr_d;
    logic [IW-1:0]      gidx_q, gidx_d;
    logic               rsp_vld_q, rsp_vld_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [NUM_REQ-1:0] gnt;
    logic [IW-1:0]      win_idx;
    logic               any_req;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .req_i (req_valid),
        .ptr_i (prio_ptr_q),
        .gnt_o (gnt),
        .idx_o (win_idx)
    );

    // ROM drive and grant outputs; the address holds its last value when idle.
    always_comb begin
        any_req   = |req_valid;
        req_ready = gnt;
        rom_en    = any_req;
        rom_addr  = any_req ? req_addr[win_idx*AW +: AW] : addr_q;
        rsp_data  = rom_data;
        rsp_valid = rsp_vld_q ? (NUM_REQ'(1) << gidx_q) : '0;
    end

    // Next-state: advance the pointer past the winner, capture the winner for the response.
    always_comb begin
        prio_ptr_d = prio_ptr_q;
        gidx_d     = gidx_q;
        rsp_vld_d  = any_req;
        addr_d     = rom_addr;
        if (any_req) begin
            prio_ptr_d = IW'(next_ptr(int'(win_idx), NUM_REQ));
            gidx_d     = win_idx;
        end
    end

    // State registers; reset drops any in-flight response immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr_q <= '0;
            gidx_q     <= '0;
            rsp_vld_q  <= 1'b0;
            addr_q     <= '0;
        end else begin
            prio_ptr_q <= prio_ptr_d;
            gidx_q     <= gidx_d;
            rsp_vld_q  <= rsp_vld_d;
            addr_q     <= addr_d;
        end
    end

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Scoreboard bench for rom_rr_arbiter with a behavioural synchronous ROM.
module tb_rom_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [11:0] req_addr;
    logic [3:0]  req_ready;
    logic [3:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [7:0]  rom_q;

    int checks = 0;
    int errors = 0;

    logic [11:0] exp_q[$];

    rom_rr_arbiter #(.WIDTH(8), .DEPTH(8), .NUM_REQ(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rom_en    (rom_en),
        .rom_addr  (rom_addr),
        .rom_data  (rom_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_word(input logic [2:0] a);
        case (a)
            3'd0: return 8'h3C;
            3'd1: return 8'hA5;
            3'd2: return 8'h5A;
            3'd3: return 8'hC3;
            3'd4: return 8'h0F;
            3'd5: return 8'hF0;
            3'd6: return 8'h96;
            default: return 8'h69;
        endcase
    endfunction

    always @(posedge clk) if (rom_en) rom_q <= rom_word(rom_addr);

    function automatic logic [11:0] pack(input logic [2:0] a0, input logic [2:0] a1,
                                         input logic [2:0] a2, input logic [2:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop one expected response per rsp_valid pulse.
    always @(negedge clk) begin
        if (rst_n && rsp_valid != 4'b0000) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h expected none", rsp_valid, rsp_data);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                chk("rsp_valid", int'(rsp_valid), int'(e[11:8]));
                chk("rsp_data", int'(rsp_data), int'(e[7:0]));
            end
        end
    end

    // One stimulus cycle: drive, check combinational outputs, queue the expected response.
    task automatic drive(input logic [3:0] v, input logic [11:0] a, input logic [3:0] er,
                         input logic [2:0] ea, input bit push);
        @(negedge clk);
        req_valid = v;
        req_addr  = a;
        #1;
        chk("req_ready", int'(req_ready), int'(er));
        chk("rom_en", int'(rom_en), (v != 4'b0000) ? 1 : 0);
        chk("rom_addr", int'(rom_addr), int'(ea));
        if (push && er != 4'b0000) exp_q.push_back({er, rom_word(ea)});
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_addr  = pack(3'd0, 3'd1, 3'd2, 3'd3);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rsp_valid", int'(rsp_valid), 0);

        @(negedge clk);
        req_valid = 4'b0000;
        rst_n     = 1'b1;
        #1;
        chk("idle_ready", int'(req_ready), 0);
        chk("idle_rom_en", int'(rom_en), 0);
        chk("idle_rom_addr", int'(rom_addr), 0);

        // Full contention: strict rotation 0,1,2,3 twice.
        for (int r = 0; r < 2; r++) begin
            drive(4'b1111, pack(3'd0, 3'd1, 3'd2, 3'd3), 4'b0001, 3'd0, 1'b1);
            drive(4'b1111, pack(3'd0, 3'd1, 3'd2, 3'd3), 4'b0010, 3'd1, 1'b1);
            drive(4'b1111, pack(3'd0, 3'd1, 3'd2, 3'd3), 4'b0100, 3'd2, 1'b1);
            drive(4'b1111, pack(3'd0, 3'd1, 3'd2, 3'd3), 4'b1000, 3'd3, 1'b1);
        end

        // Single requester 2, granted back to back.
        drive(4'b0100, pack(3'd0, 3'd0, 3'd3, 3'd0), 4'b0100, 3'd3, 1'b1);
        drive(4'b0100, pack(3'd0, 3'd0, 3'd3, 3'd0), 4'b0100, 3'd3, 1'b1);

        // Pointer at 3: requester 3 first, then wrap to 0.
        drive(4'b1001, pack(3'd0, 3'd0, 3'd0, 3'd7), 4'b1000, 3'd7, 1'b1);
        drive(4'b1001, pack(3'd0, 3'd0, 3'd0, 3'd7), 4'b0001, 3'd0, 1'b1);

        // Grant address 5, then idle: address must hold.
        drive(4'b0010, pack(3'd0, 3'd5, 3'd0, 3'd0), 4'b0010, 3'd5, 1'b1);
        repeat (3) drive(4'b0000, pack(3'd1, 3'd2, 3'd3, 3'd4), 4'b0000, 3'd5, 1'b0);

        // Mid-operation reset: grant to 0 (pointer at 2), then reset before the pulse is seen.
        drive(4'b0001, pack(3'd6, 3'd0, 3'd0, 3'd0), 4'b0001, 3'd6, 1'b0);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        chk("midreset_rsp_valid", int'(rsp_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Pointer restarted at 0 (it would have been 1 otherwise).
        drive(4'b1011, pack(3'd4, 3'd2, 3'd0, 3'd1), 4'b0001, 3'd4, 1'b1);
        drive(4'b1011, pack(3'd4, 3'd2, 3'd0, 3'd1), 4'b0010, 3'd2, 1'b1);
        drive(4'b1011, pack(3'd4, 3'd2, 3'd0, 3'd1), 4'b1000, 3'd1, 1'b1);
        drive(4'b0000, pack(3'd0, 3'd0, 3'd0, 3'd0), 4'b0000, 3'd1, 1'b0);

        repeat (3) @(negedge clk);
        #1;
        chk("pending_responses", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
Shares one synchronous-read ROM (en, addr, registered data_out) between NUM_REQ independent requesters. Each cycle it grants at most one valid request by round-robin, drives the ROM's enable and address, and routes the returned word back to the winner one cycle later. The block sits between the requester ports and the ROM instance; the ROM itself is unchanged.

Parameters:
WIDTH, 8, ROM data word width
DEPTH, 8, ROM word count; AW = $clog2(DEPTH)
NUM_REQ, 4, number of requesters (>= 2)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester read request
req_addr  input  NUM_REQ*AW  packed addresses; requester i uses bits [i*AW +: AW]
req_ready  output  NUM_REQ  one-hot grant; handshake completes when req_valid[i] & req_ready[i]
rsp_valid  output  NUM_REQ  one-hot, one-cycle pulse marking rsp_data as belonging to requester i
rsp_data  output  WIDTH  read data, shared by all requesters
rom_en  output  1  ROM read enable
rom_addr  output  AW  ROM address
rom_data  input  WIDTH  ROM data_out

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - prio_ptr = 0.
  - rsp_valid = 0.
  - Granted-index register = 0.
  - req_ready = 0, rom_en = 0, rom_addr = 0 (these are combinational and follow from req_valid = 0 / prio_ptr = 0).
- Arbitration (combinational, same cycle):
  - Search req_valid starting at prio_ptr, wrapping modulo NUM_REQ. The first set bit wins.
  - req_ready is one-hot on the winner and all-zero when no request is valid.
  - req_ready never depends on req_valid of a non-winner.
- ROM drive:
  - rom_en = |req_valid.
  - rom_addr = req_addr of the winner. When no request is valid, rom_addr holds its last value via a register; it must not toggle.
- Pointer update: on a granted cycle, prio_ptr <= winner+1, wrapping NUM_REQ-1 -> 0. With no grant, prio_ptr holds.
- Fairness: a continuously asserted request is granted within NUM_REQ cycles.
- Response latency: exactly 1 cycle.
  - A grant at edge k gives rsp_valid[winner] = 1 during cycle k+1, with rsp_data = rom_data.
  - rsp_data is a combinational pass-through of rom_data. Its value is don't-care when rsp_valid = 0.
- Throughput: one grant per cycle, fully pipelined. Back-to-back grants give back-to-back rsp_valid pulses, possibly to different requesters.
- No response backpressure: requesters must accept rsp in the pulse cycle.
- Request rules:
  - A requester may change req_addr or deassert req_valid only after its handshake, or in any cycle where it is not granted.
  - The same requester may be re-granted the next cycle only if no other request is valid.
- Boundary conditions:
  - Single requester: granted every cycle, giving full throughput.
  - All requesters valid: grants rotate in strict order 0,1,..,NUM_REQ-1,0.
  - Address DEPTH-1 is handled normally; addresses are AW bits wide, so out-of-range values cannot occur.
- Reset mid-operation:
  - rsp_valid clears immediately and asynchronously. An in-flight response is dropped and not replayed.
  - prio_ptr returns to 0.

Decomposition:
- Shared package rom_arb_pkg:
  - AW computation (function clog2-based).
  - Default WIDTH/DEPTH/NUM_REQ constants.
  - Function next_ptr(ptr) for modulo-NUM_REQ increment.
- Sub-module rr_arbiter (NUM_REQ):
  - Inputs: req vector, prio_ptr.
  - Outputs: one-hot grant and encoded winner index.
  - Purely combinational; reusable for other shared resources.
- Top level holds prio_ptr, the granted-index register, rsp_valid, the addr mux and the ROM-side signals.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 -> rsp_valid=0000. After release, first grant goes to requester 0 (req_ready=0001) and rom_en=1.
- Single request: req_valid=0100, addr[2]=3 -> req_ready=0100 and rom_addr=3 that cycle. Next cycle rsp_valid=0100 and rsp_data = ROM word 3.
- Full contention: req_valid=1111 for 8 cycles with addr[i]=i -> req_ready sequence 0001,0010,0100,1000 repeating. rsp_valid follows one cycle later, and rsp_data matches ROM words 0,1,2,3.
- Wrap/priority: prio_ptr=3 (after granting 2) with req_valid=1001 -> grant 1000, then 0001. Addresses 7 and 0 return ROM words 7 and 0.
- Idle hold: after a grant with addr=5, drop all req_valid for 3 cycles -> rom_en=0, rom_addr stays 5, rsp_valid=0 after the one pending pulse.
- Mid-operation reset: assert rst_n=0 in the cycle after a grant -> the rsp_valid pulse is suppressed. After release, the pointer restarts at requester 0.
